// File: rtl/cp0_exception_controller_pkg.sv
// ---------------------------------------------------------------------------
// cp0_exception_controller_pkg
//   Shared constants and types for the CP0 exception controller:
//   - CP0 register indices (SR, Cause, EPC, PRId)
//   - exception codes used by the controller (Int, AdEL)
//   - exception handler entry address
//   - packed field views of SR and Cause, plus helpers that turn them into
//     the architectural 32-bit register layout
// ---------------------------------------------------------------------------
package cp0_exception_controller_pkg;

  // CP0 register indices
  localparam logic [4:0] CP0_IDX_SR    = 5'd12;
  localparam logic [4:0] CP0_IDX_CAUSE = 5'd13;
  localparam logic [4:0] CP0_IDX_EPC   = 5'd14;
  localparam logic [4:0] CP0_IDX_PRID  = 5'd15;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Fetch redirect target when handle_exception is asserted
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  localparam logic [31:0] PRID_DEFAULT = 32'h5201_0000;

  // Only the implemented SR fields
  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  // Only the implemented Cause fields
  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  // SR layout: IM [15:10], EXL [1], IE [0]
  function automatic logic [31:0] sr_to_word(input sr_t s);
    return {16'h0000, s.im, 8'h00, s.exl, s.ie};
  endfunction

  // Cause layout: BD [31], IP [15:10], ExcCode [6:2]
  function automatic logic [31:0] cause_to_word(input cause_t c);
    return {c.bd, 15'h0000, c.ip, 3'b000, c.exc_code, 2'b00};
  endfunction

  // EPC is always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] w);
    return {w[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exception_controller_if.sv
// ---------------------------------------------------------------------------
// cp0_exception_controller_if
//   Commit-point bundle between the pipeline (master) and CP0 (slave).
//   master drives: exc_valid, exc_EPC, exc_ExcCode, exc_BD, HWInt,
//                  cp0_we, cp0_addr, cp0_wdata, eret
//   slave drives:  cp0_rdata, handle_exception, EPC_out, EXL
// ---------------------------------------------------------------------------
interface cp0_exception_controller_if;

  logic        exc_valid;
  logic [31:0] exc_EPC;
  logic [4:0]  exc_ExcCode;
  logic        exc_BD;
  logic [5:0]  HWInt;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret;

  logic [31:0] cp0_rdata;
  logic        handle_exception;
  logic [31:0] EPC_out;
  logic        EXL;

  modport master (
    output exc_valid, exc_EPC, exc_ExcCode, exc_BD, HWInt,
           cp0_we, cp0_addr, cp0_wdata, eret,
    input  cp0_rdata, handle_exception, EPC_out, EXL
  );

  modport slave (
    input  exc_valid, exc_EPC, exc_ExcCode, exc_BD, HWInt,
           cp0_we, cp0_addr, cp0_wdata, eret,
    output cp0_rdata, handle_exception, EPC_out, EXL
  );

endinterface

// File: rtl/cp0_exception_controller_arbiter.sv
// ---------------------------------------------------------------------------
// cp0_interrupt_arbiter
//   Purely combinational decision of whether CP0 takes an event this cycle.
//   Ports:
//     ie_i, exl_i, im_i     current SR fields
//     hwint_i               level-sensitive hardware interrupt lines
//     exc_valid_i           committed instruction carries an exception
//     int_req_o             enabled, unmasked interrupt pending
//     exc_req_o             exception request accepted (EXL clear)
//     handle_exception_o    take an event this cycle
// ---------------------------------------------------------------------------
module cp0_interrupt_arbiter (
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic [5:0] im_i,
  input  logic [5:0] hwint_i,
  input  logic       exc_valid_i,
  output logic       int_req_o,
  output logic       exc_req_o,
  output logic       handle_exception_o
);

  logic [5:0] pending;

  // A line counts only when its own mask bit is set
  for (genvar gi = 0; gi < 6; gi++) begin : g_pending
    assign pending[gi] = hwint_i[gi] & im_i[gi];
  end

  assign int_req_o          = ie_i & ~exl_i & (|pending);
  assign exc_req_o          = exc_valid_i & ~exl_i;
  assign handle_exception_o = int_req_o | exc_req_o;

endmodule

// File: rtl/cp0_exception_controller.sv
// ---------------------------------------------------------------------------
// cp0_exception_controller
//   Coprocessor 0 at the commit point: arbitrates interrupts against the
//   committed exception, records SR / Cause / EPC, and serves mtc0 / mfc0.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; clears SR, Cause and EPC
//     bus    slave side of cp0_exception_controller_if
//              handle_exception  combinational, same cycle as the request
//              cp0_rdata         combinational read of the pre-edge value
//              EPC_out / EXL     current register contents
//   Parameter:
//     PRID   read-only value returned for register 15
// ---------------------------------------------------------------------------
module cp0_exception_controller
  import cp0_exception_controller_pkg::*;
#(
  parameter logic [31:0] PRID = PRID_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  cp0_exception_controller_if.slave     bus
);

  sr_t         sr_q, sr_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic int_req;
  logic exc_req;
  logic take;
  logic wr_sr;
  logic wr_epc;

  cp0_interrupt_arbiter u_arbiter (
    .ie_i               (sr_q.ie),
    .exl_i              (sr_q.exl),
    .im_i               (sr_q.im),
    .hwint_i            (bus.HWInt),
    .exc_valid_i        (bus.exc_valid),
    .int_req_o          (int_req),
    .exc_req_o          (exc_req),
    .handle_exception_o (take)
  );

  assign wr_sr  = bus.cp0_we && (bus.cp0_addr == CP0_IDX_SR);
  assign wr_epc = bus.cp0_we && (bus.cp0_addr == CP0_IDX_EPC);

  // Next-state with per-field priority: taken event > eret > mtc0.
  always_comb begin
    sr_d    = sr_q;
    cause_d = cause_q;
    epc_d   = epc_q;

    // IM and IE are only ever changed by mtc0
    if (wr_sr) begin
      sr_d.im = bus.cp0_wdata[15:10];
      sr_d.ie = bus.cp0_wdata[0];
    end

    if (take) begin
      sr_d.exl = 1'b1;
    end else if (bus.eret) begin
      sr_d.exl = 1'b0;
    end else if (wr_sr) begin
      sr_d.exl = bus.cp0_wdata[1];
    end

    if (take) begin
      epc_d = word_align(bus.exc_EPC);
    end else if (wr_epc) begin
      epc_d = word_align(bus.cp0_wdata);
    end

    // Interrupt lines are sampled unconditionally
    cause_d.ip = bus.HWInt;

    // An interrupt wins over a simultaneous exception; the exception is
    // dropped and the instruction re-executes after eret.
    if (take) begin
      cause_d.bd       = bus.exc_BD;
      cause_d.exc_code = int_req ? EXC_INT : bus.exc_ExcCode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read mux; unimplemented indices read as zero
  always_comb begin
    bus.cp0_rdata = 32'h0000_0000;
    case (bus.cp0_addr)
      CP0_IDX_SR:    bus.cp0_rdata = sr_to_word(sr_q);
      CP0_IDX_CAUSE: bus.cp0_rdata = cause_to_word(cause_q);
      CP0_IDX_EPC:   bus.cp0_rdata = epc_q;
      CP0_IDX_PRID:  bus.cp0_rdata = PRID;
      default:       bus.cp0_rdata = 32'h0000_0000;
    endcase
  end

  assign bus.handle_exception = take;
  assign bus.EPC_out          = epc_q;
  assign bus.EXL              = sr_q.exl;

  // exc_req is folded into take by the arbiter; kept visible for debug
  logic unused_exc_req;
  assign unused_exc_req = exc_req;

endmodule

// File: tb/tb_cp0_exception_controller.sv
module tb_cp0_exception_controller;

  localparam logic [31:0] TB_PRID = 32'h5201_0000;

  logic clk;
  logic reset;

  cp0_exception_controller_if bus ();

  cp0_exception_controller #(.PRID(TB_PRID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exc_valid;
    logic [4:0]  code;
    logic [31:0] epc_in;
    logic        bd;
    logic [5:0]  hwint;
    logic        eret;
    logic        exp_h;
    logic [31:0] exp_rdata;
    logic        exp_exl;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: architectural 32-bit register words
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic vec_t mk(
    input logic rst, input logic we, input logic [4:0] addr, input logic [31:0] wdata,
    input logic exc_valid, input logic [4:0] code, input logic [31:0] epc_in,
    input logic bd, input logic [5:0] hwint, input logic eret,
    input logic exp_h, input logic [31:0] exp_rdata, input logic exp_exl,
    input logic [31:0] exp_epc);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exc_valid = exc_valid; v.code = code; v.epc_in = epc_in; v.bd = bd;
    v.hwint = hwint; v.eret = eret;
    v.exp_h = exp_h; v.exp_rdata = exp_rdata; v.exp_exl = exp_exl; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset           = v.rst;
    bus.cp0_we      = v.we;
    bus.cp0_addr    = v.addr;
    bus.cp0_wdata   = v.wdata;
    bus.exc_valid   = v.exc_valid;
    bus.exc_ExcCode = v.code;
    bus.exc_EPC     = v.epc_in;
    bus.exc_BD      = v.bd;
    bus.HWInt       = v.hwint;
    bus.eret        = v.eret;
  endtask

  // Apply one cycle, check outputs mid-cycle against given expectations
  task automatic run_vec(input string tag, input vec_t v);
    drive(v);
    @(negedge clk);
    check32({tag, ".handle"}, {31'd0, bus.handle_exception}, {31'd0, v.exp_h});
    check32({tag, ".rdata"},  bus.cp0_rdata, v.exp_rdata);
    check32({tag, ".EXL"},    {31'd0, bus.EXL}, {31'd0, v.exp_exl});
    check32({tag, ".EPC_out"}, bus.EPC_out, v.exp_epc);
    $display("%s rst=%0b we=%0b addr=%0d exc=%0b hw=%b eret=%0b -> h=%0b rdata=%h exl=%0b epc=%h",
             tag, v.rst, v.we, v.addr, v.exc_valid, v.hwint, v.eret,
             bus.handle_exception, bus.cp0_rdata, bus.EXL, bus.EPC_out);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd12) return m_sr;
    if (a == 5'd13) return m_cause;
    if (a == 5'd14) return m_epc;
    if (a == 5'd15) return TB_PRID;
    return 32'h0;
  endfunction

  function automatic logic model_take(input vec_t v, output logic is_int);
    logic ie, exl;
    ie  = m_sr[0];
    exl = m_sr[1];
    is_int = ie && !exl && ((v.hwint & m_sr[15:10]) != 6'd0);
    return is_int || (v.exc_valid && !exl);
  endfunction

  // Model update: apply lower-priority effects first, then let higher ones overwrite
  task automatic model_step(input vec_t v);
    logic is_int, tk;
    logic [31:0] sr_n, cause_n, epc_n;
    tk = model_take(v, is_int);
    sr_n = m_sr; cause_n = m_cause; epc_n = m_epc;
    if (v.we && v.addr == 5'd12) sr_n = v.wdata & 32'h0000_FC03;
    if (v.we && v.addr == 5'd14) epc_n = v.wdata & 32'hFFFF_FFFC;
    if (v.eret) sr_n = sr_n & ~32'h2;
    cause_n = (cause_n & ~32'h0000_FC00) | (32'(v.hwint) << 10);
    if (tk) begin
      sr_n = sr_n | 32'h2;
      epc_n = v.epc_in & 32'hFFFF_FFFC;
      cause_n = (cause_n & 32'h7FFF_FF83) | (32'(v.bd) << 31) |
                (is_int ? 32'h0 : (32'(v.code) << 2));
    end
    if (v.rst) begin
      sr_n = 0; cause_n = 0; epc_n = 0;
    end
    m_sr = sr_n; m_cause = cause_n; m_epc = epc_n;
  endtask

  task automatic run_model(input string tag, input vec_t v);
    logic is_int;
    v.exp_h     = model_take(v, is_int);
    v.exp_rdata = model_read(v.addr);
    v.exp_exl   = m_sr[1];
    v.exp_epc   = m_epc;
    run_vec(tag, v);
    model_step(v);
  endtask

  initial begin
    vec_t v;
    // rst we addr wdata exc code epc bd hw eret | h rdata exl epc
    tbl.push_back(mk(0,0,12,0,           0,0, 0,      0,6'd0,0, 0,32'h0,         0,32'h0));
    tbl.push_back(mk(0,0,14,0,           1,4, 32'h3004,1,6'd0,0, 1,32'h0,         0,32'h0));
    tbl.push_back(mk(0,0,14,0,           0,0, 0,      0,6'd0,0, 0,32'h3004,      1,32'h3004));
    tbl.push_back(mk(0,0,13,0,           0,0, 0,      0,6'd0,0, 0,32'h8000_0010, 1,32'h3004));
    tbl.push_back(mk(0,0,12,0,           0,0, 0,      0,6'd0,0, 0,32'h2,         1,32'h3004));
    tbl.push_back(mk(0,0,14,0,           1,5, 32'h5000,0,6'd0,0, 0,32'h3004,      1,32'h3004));
    tbl.push_back(mk(0,0,14,0,           0,0, 0,      0,6'd0,0, 0,32'h3004,      1,32'h3004));
    tbl.push_back(mk(0,0,12,0,           0,0, 0,      0,6'd0,1, 0,32'h2,         1,32'h3004));
    tbl.push_back(mk(0,0,12,0,           0,0, 0,      0,6'd0,0, 0,32'h0,         0,32'h3004));
    tbl.push_back(mk(0,1,12,32'h401,     0,0, 0,      0,6'd0,0, 0,32'h0,         0,32'h3004));
    tbl.push_back(mk(0,0,12,0,           1,10,32'h6000,0,6'd1,0, 1,32'h401,       0,32'h3004));
    tbl.push_back(mk(0,0,13,0,           0,0, 0,      0,6'd1,0, 0,32'h400,       1,32'h6000));
    tbl.push_back(mk(0,0,14,0,           0,0, 0,      0,6'd0,0, 0,32'h6000,      1,32'h6000));
    tbl.push_back(mk(0,1,14,32'h3007,    0,0, 0,      0,6'd0,0, 0,32'h6000,      1,32'h6000));
    tbl.push_back(mk(0,0,14,0,           0,0, 0,      0,6'd0,0, 0,32'h3004,      1,32'h3004));
    tbl.push_back(mk(0,1,13,32'hFFFF_FFFF,0,0,0,      0,6'd0,0, 0,32'h0,         1,32'h3004));
    tbl.push_back(mk(0,0,13,0,           0,0, 0,      0,6'd0,0, 0,32'h0,         1,32'h3004));
    tbl.push_back(mk(0,0,15,0,           0,0, 0,      0,6'd0,0, 0,TB_PRID,       1,32'h3004));
    tbl.push_back(mk(0,0,7, 0,           0,0, 0,      0,6'd0,0, 0,32'h0,         1,32'h3004));
    tbl.push_back(mk(0,0,12,0,           0,0, 0,      0,6'd1,1, 0,32'h403,       1,32'h3004));
    tbl.push_back(mk(0,0,12,0,           0,0, 32'h7000,0,6'd1,0, 1,32'h401,       0,32'h3004));
    tbl.push_back(mk(0,0,12,0,           0,0, 0,      0,6'd0,1, 0,32'h403,       1,32'h7000));
    tbl.push_back(mk(0,1,12,32'h0,       1,12,32'h8000,0,6'd0,0, 1,32'h401,       0,32'h7000));
    tbl.push_back(mk(0,0,12,0,           0,0, 0,      0,6'd0,0, 0,32'h2,         1,32'h8000));
    tbl.push_back(mk(0,0,13,0,           0,0, 0,      0,6'd0,0, 0,32'h30,        1,32'h8000));
    tbl.push_back(mk(0,0,12,0,           0,0, 0,      0,6'd0,1, 0,32'h2,         1,32'h8000));
    tbl.push_back(mk(1,0,14,0,           1,4, 32'h9000,1,6'd1,0, 1,32'h8000,      0,32'h8000));
    tbl.push_back(mk(0,0,14,0,           0,0, 0,      0,6'd0,0, 0,32'h0,         0,32'h0));
    tbl.push_back(mk(0,0,13,0,           0,0, 0,      0,6'd0,0, 0,32'h0,         0,32'h0));
    tbl.push_back(mk(0,0,12,0,           0,0, 0,      0,6'd0,0, 0,32'h0,         0,32'h0));

    v = mk(1,0,0,0,0,0,0,0,6'd0,0, 0,0,0,0);
    drive(v);
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Hand sequence: eret and an exception together while EXL=0 -- the take
    // wins, EXL ends at 1 and EPC picks up the exception address.
    m_sr = 0; m_cause = 0; m_epc = 0;
    v = mk(1,0,12,0,0,0,0,0,6'd0,0, 0,0,0,0);
    run_model("hand_rst", v);
    v = mk(0,0,12,0,1,6,32'hA00B,0,6'd0,1, 0,0,0,0);
    run_model("hand_eret_exc", v);
    v = mk(0,0,13,0,0,0,0,0,6'd0,0, 0,0,0,0);
    run_model("hand_after", v);
    check32("hand_epc_aligned", bus.EPC_out, 32'h0000_A008);
    check32("hand_exl_set", {31'd0, bus.EXL}, 32'd1);

    // Randomized run against the reference model
    for (int n = 0; n < 400; n++) begin
      v.rst       = ($urandom_range(0, 39) == 0);
      v.we        = ($urandom_range(0, 3) == 0);
      v.addr      = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      v.wdata     = $urandom;
      v.exc_valid = ($urandom_range(0, 2) == 0);
      v.code      = 5'($urandom);
      v.epc_in    = $urandom;
      v.bd        = 1'($urandom);
      v.hwint     = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
      v.eret      = ($urandom_range(0, 5) == 0);
      run_model($sformatf("rnd%0d", n), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
